// File: rtl/ws2812b_frame_loader.sv
`default_nettype none
// =============================================================================
// ws2812b_frame_loader : periodic, brightness-scaled, rotatable frame streamer
// Revision 1.0
// =============================================================================
module ws2812b_frame_loader #(
  parameter int NB_LEDS     = 12,
  parameter int REFRESH_DIV = 2_500_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [23:0] wr_rgb,
  input  logic [7:0]  brightness,
  input  logic        rotate_en,
  input  logic        rotate_dir,
  output logic [7:0]  address,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        load,
  output logic        latch_n,
  output logic        frame_done
);

  localparam int               c_cnt_w    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [7:0]       c_leds     = 8'(NB_LEDS);
  localparam logic [7:0]       c_led_last = 8'(NB_LEDS - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t             r_state, w_state_nx;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nx;
  logic [7:0]         r_idx, w_idx_nx;
  logic [7:0]         r_off, w_off_nx;
  logic [7:0]         r_bright;
  logic               w_start;
  logic [7:0]         w_off_inc, w_off_dec;
  logic [7:0]         w_src;
  logic [23:0]        w_pix;
  logic [8:0]         w_scale;
  logic [23:0]        r_buf [NB_LEDS];

  assign w_off_inc = (r_off == c_led_last) ? 8'd0 : r_off + 8'd1;
  assign w_off_dec = (r_off == 8'd0) ? c_led_last : r_off - 8'd1;

  // (k - off) mod NB_LEDS; the wrap branch stays below 256 even if the 8-bit sum overflows
  assign w_src   = (r_idx >= r_off) ? (r_idx - r_off) : (r_idx + (c_leds - r_off));
  assign w_scale = {1'b0, r_bright} + 9'd1;

  always_comb begin
    w_pix = '0;
    for (int i = 0; i < NB_LEDS; i++) begin
      if (w_src == 8'(i)) w_pix = r_buf[i];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_off_nx   = r_off;
    w_start    = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == c_cnt_last) begin
          w_state_nx = ST_LOAD;
          w_idx_nx   = 8'd0;
          w_start    = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + c_cnt_w'(1);
        end
      end
      ST_LOAD: begin
        if (r_idx == c_led_last) w_state_nx = ST_LATCH;
        else                     w_idx_nx   = r_idx + 8'd1;
      end
      ST_LATCH: begin
        w_state_nx = ST_WAIT;
        w_cnt_nx   = '0;
        if (rotate_en) w_off_nx = rotate_dir ? w_off_dec : w_off_inc;
      end
      default: w_state_nx = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_WAIT;
      r_cnt    <= '0;
      r_idx    <= 8'd0;
      r_off    <= 8'd0;
      r_bright <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_off   <= w_off_nx;
      if (w_start) r_bright <= brightness;
    end
  end

  // Out-of-range addresses match no entry and are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB_LEDS; i++) r_buf[i] <= '0;
    end else begin
      for (int i = 0; i < NB_LEDS; i++) begin
        if (wr_en && (wr_addr == 8'(i))) r_buf[i] <= wr_rgb;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load       <= 1'b0;
      latch_n    <= 1'b1;
      frame_done <= 1'b0;
      address    <= 8'd0;
      red        <= 8'd0;
      green      <= 8'd0;
      blue       <= 8'd0;
    end else begin
      load       <= (r_state == ST_LOAD);
      latch_n    <= (r_state != ST_LATCH);
      frame_done <= (r_state == ST_LATCH);
      if (r_state == ST_LOAD) begin
        address <= r_idx;
        red     <= 8'(({8'd0, w_pix[23:16]} * {7'd0, w_scale}) >> 8);
        green   <= 8'(({8'd0, w_pix[15:8]}  * {7'd0, w_scale}) >> 8);
        blue    <= 8'(({8'd0, w_pix[7:0]}   * {7'd0, w_scale}) >> 8);
      end else begin
        address <= 8'd0;
        red     <= 8'd0;
        green   <= 8'd0;
        blue    <= 8'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_frame_loader.sv
`default_nettype none
// tb_ws2812b_frame_loader : randomized frames checked against a frame-level
// reference model (buffer array, rotation offset, brightness arithmetic).
module tb_ws2812b_frame_loader;
  localparam int N = 12;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [23:0] wr_rgb = 24'd0;
  logic [7:0]  brightness = 8'hFF;
  logic        rotate_en = 1'b0;
  logic        rotate_dir = 1'b0;
  logic [7:0]  address, red, green, blue;
  logic        load, latch_n, frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int moff = 0;
  logic [23:0] mbuf [N];
  logic [23:0] v;

  ws2812b_frame_loader #(.NB_LEDS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .brightness(brightness), .rotate_en(rotate_en), .rotate_dir(rotate_dir),
    .address(address), .red(red), .green(green), .blue(blue),
    .load(load), .latch_n(latch_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] scale_rgb(input logic [23:0] c, input int b);
    int r, g, bl;
    r  = (int'(c[23:16]) * (b + 1)) / 256;
    g  = (int'(c[15:8])  * (b + 1)) / 256;
    bl = (int'(c[7:0])   * (b + 1)) / 256;
    return {8'(r), 8'(g), 8'(bl)};
  endfunction

  task automatic model_write(input int a, input logic [23:0] val);
    if (a < N) mbuf[a] = val;
  endtask

  task automatic advance_off();
    if (rotate_en) moff = rotate_dir ? (moff + N - 1) % N : (moff + 1) % N;
  endtask

  task automatic do_write(input int a, input logic [23:0] val);
    wr_en = 1'b1; wr_addr = 8'(a); wr_rgb = val;
    @(negedge clk);
    wr_en = 1'b0;
    model_write(a, val);
  endtask

  task automatic sync_latch();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (latch_n !== 1'b0 && n < 100);
    chk("sync_latch", 32'(latch_n), 32'd0);
    advance_off();
    ref_cyc = cyc;
  endtask

  // Checks gap, the N load cycles and the latch pulse of the next frame.
  // Optionally issues one write (at observation wr_at) and a brightness change (at br_at).
  task automatic check_frame(input string tag, input int wr_at, input int wa, input logic [23:0] wv,
                             input int br_at, input logic [7:0] nb);
    logic [23:0] exp [N];
    int n = 0;
    int fb;
    do begin
      @(negedge clk);
      n++;
      if (load !== 1'b1) begin
        chk({tag, "_idle_latch_n"}, 32'(latch_n), 32'd1);
        chk({tag, "_idle_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_idle_out"}, {address, red, green, blue}, 32'd0);
      end
    end while (load !== 1'b1 && n < 64);
    chk({tag, "_load_start"}, 32'(load), 32'd1);
    chk({tag, "_start_delay"}, 32'(cyc - ref_cyc), 32'(R + 1));
    fb = int'(brightness);
    for (int k = 0; k < N; k++) exp[k] = scale_rgb(mbuf[(k - moff + N) % N], fb);
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      wr_en = 1'b0;
      chk($sformatf("%s_load%0d", tag, k), 32'(load), 32'd1);
      chk($sformatf("%s_addr%0d", tag, k), 32'(address), 32'(k));
      chk($sformatf("%s_rgb%0d", tag, k), {8'd0, red, green, blue}, {8'd0, exp[k]});
      if (k == br_at) brightness = nb;
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = 8'(wa); wr_rgb = wv;
        model_write(wa, wv);
        for (int j = k + 2; j < N; j++)
          if (wa < N && ((j - moff + N) % N) == wa) exp[j] = scale_rgb(wv, fb);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk({tag, "_latch_load"}, 32'(load), 32'd0);
    chk({tag, "_latch_n"}, 32'(latch_n), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    advance_off();
    ref_cyc = cyc;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mbuf[i] = 24'd0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_latch_n", 32'(latch_n), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_out", {address, red, green, blue}, 32'd0);
    reset_n = 1'b1;
    ref_cyc = cyc;
    check_frame("first", -1, 0, 24'd0, -1, 8'd0);

    // Pass-through frame with random contents
    for (int i = 0; i < N; i++) begin
      v = 24'($urandom);
      do_write(i, v);
    end
    do_write(0, 24'h200000);
    do_write(1, 24'h002000);
    brightness = 8'hFF;
    sync_latch();
    check_frame("pass", -1, 0, 24'd0, -1, 8'd0);

    // Random brightness and random writes, some beyond the ring
    repeat (3) begin
      brightness = 8'($urandom);
      repeat (4) begin
        v = 24'($urandom);
        do_write(int'($urandom_range(0, 15)), v);
      end
      sync_latch();
      check_frame("rand", -1, 0, 24'd0, -1, 8'd0);
    end

    do_write(0, 24'hFFFFFF);
    brightness = 8'h7F;
    sync_latch();
    check_frame("bri7f", -1, 0, 24'd0, -1, 8'd0);
    brightness = 8'h00;
    check_frame("bri00", -1, 0, 24'd0, -1, 8'd0);
    brightness = 8'hFF;
    check_frame("bri_hold", -1, 0, 24'd0, 5, 8'h40);
    check_frame("bri_next", -1, 0, 24'd0, -1, 8'd0);

    // Write collision and write to an already-streamed entry
    brightness = 8'hFF;
    v = 24'($urandom);
    check_frame("coll", 4, 5, v, -1, 8'd0);
    v = 24'($urandom);
    check_frame("coll_next", 8, 2, v, -1, 8'd0);
    check_frame("streamed_next", -1, 0, 24'd0, -1, 8'd0);

    do_write(12, 24'h123456);
    do_write(255, 24'h654321);
    sync_latch();
    check_frame("wr_oob", -1, 0, 24'd0, -1, 8'd0);

    // Rotation: one red pixel walks up for 13 frames, then reverses
    for (int i = 0; i < N; i++) do_write(i, (i == 0) ? 24'hFF0000 : 24'h000000);
    sync_latch();
    rotate_en = 1'b1;
    rotate_dir = 1'b0;
    for (int f = 0; f < 14; f++) begin
      check_frame($sformatf("rot%0d", f), -1, 0, 24'd0, -1, 8'd0);
      if (f == 11) rotate_dir = 1'b1;
    end
    rotate_en = 1'b0;

    // Reset in the middle of a frame
    v = 24'hABCDEF;
    do_write(3, v);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (load !== 1'b1 && n < 64);
      chk("pre_rst_load", 32'(load), 32'd1);
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_load", 32'(load), 32'd0);
    chk("mid_rst_latch_n", 32'(latch_n), 32'd1);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    chk("mid_rst_out", {address, red, green, blue}, 32'd0);
    for (int i = 0; i < N; i++) mbuf[i] = 24'd0;
    moff = 0;
    @(negedge clk);
    reset_n = 1'b1;
    ref_cyc = cyc;
    check_frame("post_rst", -1, 0, 24'd0, -1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ws2812b_frame_loader.md
# ws2812b_frame_loader

Frame-buffer sequencer that sits directly upstream of `ws2812b_controller` and drives its `address`/`red`/`green`/`blue`/`load`/`latch_n` load port. It holds a per-LED colour buffer written by a simple write port and periodically streams one full frame into the controller register. Each frame is followed by a single latch pulse. The block applies a global brightness scale and an optional ring rotation that advances one position per frame.

## Interface

Parameters:
- `NB_LEDS`, 12: number of LEDs in the ring (1..255).
- `REFRESH_DIV`, 2_500_000: idle cycles between frames (≥1).

Ports:
- `clk` input 1: system clock; one clock domain.
- `reset_n` input 1: reset, asynchronous and active-low.
- `wr_en` input 1: buffer write strobe.
- `wr_addr` input 8: LED index to write.
- `wr_rgb` input 24: colour to write, {R[23:16], G[15:8], B[7:0]}.
- `brightness` input 8: global scale, where 255 means pass-through.
- `rotate_en` input 1: advance the rotation offset once per frame.
- `rotate_dir` input 1: 0 means the pattern moves toward higher addresses; 1 means toward lower addresses.
- `address` output 8: LED index to the controller.
- `red`, `green`, `blue` output 8 each: scaled colour to the controller.
- `load` output 1: controller register load enable.
- `latch_n` output 1: controller transfer, active-low single-cycle pulse.
- `frame_done` output 1: one-cycle pulse, coincident with `latch_n`=0.

## Operation

- Buffer: `NB_LEDS` × 24-bit registers. All entries are cleared to 0 on reset.
- Writes: `wr_en`=1 with `wr_addr` < `NB_LEDS` updates the entry at the clock edge. Writes with `wr_addr` ≥ `NB_LEDS` are ignored.
- Writes are accepted in every state.
- FSM states:
  - WAIT: counter counts 0..`REFRESH_DIV`-1, then moves to LOAD with index 0.
  - LOAD: index k runs 0..`NB_LEDS`-1, one value per cycle. After the last index, moves to LATCH.
  - LATCH: lasts one cycle, then moves to WAIT with the counter cleared.
- Reset state is WAIT with counter=0.
- Rotation offset:
  - `off` is in the range 0..`NB_LEDS`-1, with reset value 0.
  - Output index k reads buffer[(k − off) mod `NB_LEDS`].
  - In the LATCH cycle, if `rotate_en`=1: `off` becomes `off`+1 when `rotate_dir`=0, or `off`−1 when `rotate_dir`=1, wrapping modulo `NB_LEDS`.
  - The new offset applies to the next frame.
  - `rotate_en` and `rotate_dir` are sampled only in the LATCH cycle.
- Brightness:
  - `brightness` is captured on entry to LOAD, so the whole frame uses one value.
  - Each channel is computed as out = (c × (b+1)) >> 8. The product is 16 bits unsigned and bits [15:8] are taken.
  - b=255 gives out=c. b=0 gives out=0 for every c.
- Index arithmetic: use a subtract-with-wrap on the offset. No division or modulo operators.

## Timing

- All outputs are registered.
- Reset values:
  - `load`=0, `latch_n`=1, `frame_done`=0.
  - `address`=0, `red`/`green`/`blue`=0.
- Frame window: `load`=1 for exactly `NB_LEDS` consecutive cycles. During that window, `address` takes 0,1,…,`NB_LEDS`-1 in order, with matching colour on the same cycle.
- Latch: on the cycle immediately after the last `load`=1 cycle, `latch_n`=0 and `frame_done`=1 for exactly one cycle. `load`=0 in that cycle.
- Outside the load and latch cycles: `load`=0, `latch_n`=1, `address`=0, colour=0.
- First frame: the first `load` is asserted `REFRESH_DIV`+1 cycles after `reset_n` deasserts.
- Frame period is `NB_LEDS`+1+`REFRESH_DIV` cycles.
- Write/read collision: a write to the entry being read in the same cycle outputs the old value. The new value appears from the next frame.
- A write to an entry already streamed in the current frame appears next frame.
- Reset mid-operation: outputs return to reset values immediately (asynchronously). `latch_n` stays 1, so a partial frame is never latched. The buffer and offset are cleared.
- `NB_LEDS`=1: the offset stays 0 regardless of `rotate_en`.

## Test plan

- Reset check: assert `reset_n`=0 mid-LOAD. Required: `load`=0, `latch_n`=1, all colour outputs 0 immediately. The next `load` follows `REFRESH_DIV`+1 cycles after release, and no latch pulse occurs before that.
- Pass-through frame (`REFRESH_DIV`=4): write led[i]=0x200000, led[1]=0x002000 and the others, `brightness`=255. Required: 12 `load` cycles carrying addresses 0..11 with the exact written values, then one `latch_n`=0/`frame_done`=1 cycle, then 4 idle cycles.
- Brightness scaling: led[0]=0xFFFFFF.
  - `brightness`=0x7F gives 0x7F7F7F.
  - `brightness`=0x00 gives 0x000000.
  - `brightness` changed mid-frame leaves the current frame unchanged.
- Rotation: buffer[0]=0xFF0000, all others 0, `rotate_en`=1.
  - `rotate_dir`=0: frame n shows red at address n mod 12, and the 13th frame shows it at address 0.
  - `rotate_dir`=1 from `off`=0: the next frame shows red at address 11.
- Write boundaries:
  - A write with `wr_addr`=12 leaves the buffer unchanged.
  - A write to address 5 in the same cycle it is streamed outputs the old value in that frame and the new value in the next frame.
